// File: rtl/hc_sr04_pkg.sv
// Shared HC-SR04 constants and FSM encoding.
// Used by the echo receiver and the trigger generator.
package hc_sr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RISE,
        MEASURE,
        CONVERT,
        DONE
    } state_t;

    localparam int US_PER_CM       = 58;
    localparam int CLKS_PER_US_DEF = 50;
    localparam int TIMEOUT_US_DEF  = 38000;
    localparam int US_W_DEF        = 16;
    localparam int CM_W_DEF        = 10;

endpackage

// File: rtl/hc_sr04_us_tick.sv
// Restartable one-microsecond tick generator.
// tick is high for one cycle when the count reaches CLKS_PER_US-1.
module hc_sr04_us_tick
    import hc_sr04_pkg::*;
#(
    parameter int CLKS_PER_US = CLKS_PER_US_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/hc_sr04_echo_rx.sv
// HC-SR04 echo receiver: times the ECHO pulse in microseconds.
// Define HC_SR04_DIST_CM_EN to build the centimetre divider.
module hc_sr04_echo_rx
    import hc_sr04_pkg::*;
#(
    parameter int CLKS_PER_US = CLKS_PER_US_DEF,
    parameter int TIMEOUT_US  = TIMEOUT_US_DEF,
    parameter int US_W        = US_W_DEF,
    parameter int CM_W        = CM_W_DEF
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            start,
    input  logic            echo,
    output logic            busy,
    output logic            meas_valid,
    output logic [US_W-1:0] echo_us,
    output logic [CM_W-1:0] dist_cm,
    output logic            timeout
);

    localparam logic [US_W-1:0] TO_US = US_W'(TIMEOUT_US);

    state_t          state;
    logic            sync_a;
    logic            sync_b;
    logic            echo_d;
    logic            rise;
    logic            fall;
    logic            tick;
    logic            accept;
    logic [US_W-1:0] us_cnt;
    logic [US_W-1:0] res_us;
    logic            res_to;

`ifdef HC_SR04_DIST_CM_EN
    localparam state_t MEAS_EXIT = CONVERT;
    localparam logic [US_W-1:0] DIV = US_W'(US_PER_CM);
    logic [US_W-1:0] div_rem;
    logic [CM_W-1:0] div_q;
`else
    localparam state_t MEAS_EXIT = DONE;
    assign dist_cm = '0;
`endif

    assign accept = start && (state == IDLE);
    assign rise   = sync_b && !echo_d;
    assign fall   = !sync_b && echo_d;

    hc_sr04_us_tick #(
        .CLKS_PER_US(CLKS_PER_US)
    ) u_tick (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .restart(accept),
        .tick   (tick)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            sync_a <= echo;
            sync_b <= sync_a;
            echo_d <= sync_b;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            echo_us    <= '0;
            timeout    <= 1'b0;
            us_cnt     <= '0;
            res_us     <= '0;
            res_to     <= 1'b0;
`ifdef HC_SR04_DIST_CM_EN
            dist_cm    <= '0;
            div_rem    <= '0;
            div_q      <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    meas_valid <= 1'b0;
                    busy       <= 1'b0;
                    if (start) begin
                        state  <= WAIT_RISE;
                        busy   <= 1'b1;
                        us_cnt <= '0;
                    end
                end
                WAIT_RISE: begin
                    if (rise) begin
                        state  <= MEASURE;
                        us_cnt <= '0;
                    end else if (us_cnt == TO_US) begin
                        state  <= DONE;
                        res_us <= '0;
                        res_to <= 1'b1;
`ifdef HC_SR04_DIST_CM_EN
                        div_q  <= '0;
`endif
                    end else if (tick) begin
                        us_cnt <= us_cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (fall) begin
                        state   <= MEAS_EXIT;
                        res_us  <= us_cnt;
                        res_to  <= 1'b0;
`ifdef HC_SR04_DIST_CM_EN
                        div_rem <= us_cnt;
                        div_q   <= '0;
`endif
                    end else if (us_cnt == TO_US) begin
                        // Echo stuck high: saturate at the no-object width
                        state   <= MEAS_EXIT;
                        res_us  <= TO_US;
                        res_to  <= 1'b1;
`ifdef HC_SR04_DIST_CM_EN
                        div_rem <= TO_US;
                        div_q   <= '0;
`endif
                    end else if (tick) begin
                        us_cnt <= us_cnt + 1'b1;
                    end
                end
                CONVERT: begin
`ifdef HC_SR04_DIST_CM_EN
                    if (div_rem >= DIV) begin
                        div_rem <= div_rem - DIV;
                        div_q   <= div_q + 1'b1;
                    end else begin
                        state <= DONE;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    meas_valid <= 1'b1;
                    echo_us    <= res_us;
                    timeout    <= res_to;
`ifdef HC_SR04_DIST_CM_EN
                    dist_cm    <= div_q;
`endif
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hc_sr04_echo_rx.sv
// Directed bench for hc_sr04_echo_rx with scaled-down timing.
// Follows HC_SR04_DIST_CM_EN for the expected distance and latency.
module tb_hc_sr04_echo_rx;

    localparam int CPU = 4;
    localparam int TO  = 700;

`ifdef HC_SR04_DIST_CM_EN
    localparam bit DIST_EN = 1'b1;
`else
    localparam bit DIST_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        echo;
    logic        busy;
    logic        meas_valid;
    logic [15:0] echo_us;
    logic [9:0]  dist_cm;
    logic        timeout;

    int checks   = 0;
    int failures = 0;
    int vtotal   = 0;
    int base;
    int n;

    hc_sr04_echo_rx #(
        .CLKS_PER_US(CPU),
        .TIMEOUT_US (TO),
        .US_W       (16),
        .CM_W       (10)
    ) dut (
        .sys_clk   (clk),
        .sys_rst   (rst),
        .start     (start),
        .echo      (echo),
        .busy      (busy),
        .meas_valid(meas_valid),
        .echo_us   (echo_us),
        .dist_cm   (dist_cm),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (meas_valid === 1'b1) vtotal = vtotal + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_rng(input string tag, input logic [31:0] obs,
                           input int lo, input int hi);
        logic ok;
        ok = (obs >= lo) && (obs <= hi);
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int maxc, output int cnt);
        cnt = 0;
        while (meas_valid !== 1'b1 && cnt < maxc) begin
            step(1);
            cnt++;
        end
        chk({tag, "_valid_seen"}, meas_valid, 1);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        step(3);
        rst = 1'b0;
        chk("rst_valid", meas_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_echo_us", echo_us, 0);
        chk("rst_dist", dist_cm, 0);
        chk("rst_timeout", timeout, 0);
        step(2);

        // 1: 300 us pulse
        base = vtotal;
        pulse_start();
        chk("t1_busy", busy, 1);
        step(10 * CPU);
        echo = 1'b1;
        step(300 * CPU);
        echo = 1'b0;
        wait_valid("t1", 40, n);
        chk_rng("t1_echo_us", echo_us, 299, 301);
        chk("t1_dist", dist_cm, DIST_EN ? 5 : 0);
        chk("t1_timeout", timeout, 0);
        chk("t1_busy_at_valid", busy, 1);
        step(1);
        chk("t1_valid_drop", meas_valid, 0);
        chk("t1_busy_drop", busy, 0);
        chk("t1_one_valid", vtotal - base, 1);

        // 2: echo never rises
        step(5);
        pulse_start();
        wait_valid("t2", 3000, n);
        chk_rng("t2_latency", n, 2800, 2804);
        chk("t2_timeout", timeout, 1);
        chk("t2_echo_us", echo_us, 0);
        chk("t2_dist", dist_cm, 0);

        // 3: echo stuck high
        step(5);
        pulse_start();
        step(20);
        echo = 1'b1;
        wait_valid("t3", 3000, n);
        chk("t3_echo_us", echo_us, TO);
        chk("t3_dist", dist_cm, DIST_EN ? 12 : 0);
        chk("t3_timeout", timeout, 1);
        echo = 1'b0;
        step(10);

        // 4: ignored second start mid-pulse
        base = vtotal;
        pulse_start();
        step(20);
        echo = 1'b1;
        step(200);
        pulse_start();
        step(600 * CPU - 201);
        echo = 1'b0;
        wait_valid("t4", 40, n);
        chk_rng("t4_echo_us", echo_us, 599, 601);
        chk("t4_dist", dist_cm, DIST_EN ? 10 : 0);
        chk("t4_timeout", timeout, 0);
        step(1);
        chk("t4_one_valid", vtotal - base, 1);

        // 5: reset mid-measurement
        step(5);
        base = vtotal;
        pulse_start();
        step(20);
        echo = 1'b1;
        step(100);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("t5_valid", meas_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_echo_us", echo_us, 0);
        chk("t5_dist", dist_cm, 0);
        chk("t5_timeout", timeout, 0);
        step(50);
        echo = 1'b0;
        step(30);
        chk("t5_no_valid", vtotal - base, 0);
        pulse_start();
        step(20);
        echo = 1'b1;
        step(120 * CPU);
        echo = 1'b0;
        wait_valid("t5b", 40, n);
        chk_rng("t5b_echo_us", echo_us, 119, 121);
        chk("t5b_dist", dist_cm, DIST_EN ? 2 : 0);

        // 6: fall-to-valid latency on a 70 us pulse
        step(5);
        pulse_start();
        step(20);
        echo = 1'b1;
        step(70 * CPU);
        echo = 1'b0;
        n = 0;
        while (meas_valid !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk("t6_latency", n, DIST_EN ? 6 : 4);
        chk_rng("t6_echo_us", echo_us, 69, 71);
        chk("t6_dist", dist_cm, DIST_EN ? 1 : 0);
        chk("t6_timeout", timeout, 0);
        step(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
